// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered multicycle ALU with a start/busy/done handshake.
// In: clk, reset, start, A, B, ALUControl. Out: Result, ResultHi, Zero, busy, done, div_zero.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  // mcand holds the multiplicand or the divisor.
  // lo shifts out multiplier bits / dividend bits and
  // shifts in product low bits / quotient bits.
  // hi accumulates the product high half or the remainder.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             b_zero;
  logic             last;
  logic [WIDTH-1:0] sc_res;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_q;

  assign accept = start && (state == IDLE || state == DONE);
  assign is_mul = (ALUControl == OP_MULTU);
  assign is_div = (ALUControl == OP_DIVU);
  assign b_zero = (B == '0);
  assign last   = (cnt == CNT_W'(1));

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == DONE);

  // Single-cycle result; unlisted opcodes yield zero.
  always_comb begin
    sc_res = '0;
    unique case (ALUControl)
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_ADD:  sc_res = A + B;
      OP_SUB:  sc_res = A - B;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  sc_res = ~(A | B);
      default: sc_res = '0;
    endcase
  end

  // Shift-add step: conditional add into hi, then
  // shift {carry, hi, lo} right by one.
  always_comb begin
    mul_sum = {1'b0, hi};
    if (lo[0]) begin
      mul_sum = {1'b0, hi} + {1'b0, mcand};
    end
    mul_lo = {mul_sum[0], lo[WIDTH-1:1]};
  end

  // Restoring step: bring in next dividend bit, try
  // subtracting the divisor, keep it when non-negative.
  // The partial remainder stays below 2*divisor, so
  // bit WIDTH of the difference is a valid sign bit.
  always_comb begin
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0]
                       : div_shift[WIDTH-1:0];
    div_q     = {lo[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
          if (is_mul) begin
            state_next = MUL;
          end else if (is_div && !b_zero) begin
            state_next = DIV;
          end else begin
            state_next = DONE;
          end
        end
      end
      MUL: begin
        if (last) state_next = DONE;
      end
      DIV: begin
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      mcand    <= '0;
      lo       <= '0;
      hi       <= '0;
      Result   <= '0;
      ResultHi <= '0;
      Zero     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            div_zero <= 1'b0;
            cnt      <= CNT_W'(WIDTH);
            hi       <= '0;
            if (is_mul) begin
              mcand <= A;
              lo    <= B;
            end else if (is_div && !b_zero) begin
              mcand <= B;
              lo    <= A;
            end else if (is_div) begin
              Result   <= '1;
              ResultHi <= A;
              Zero     <= 1'b0;
              div_zero <= 1'b1;
            end else begin
              Result   <= sc_res;
              ResultHi <= '0;
              Zero     <= (sc_res == '0);
            end
          end
        end
        MUL: begin
          cnt <= cnt - CNT_W'(1);
          hi  <= mul_sum[WIDTH:1];
          lo  <= mul_lo;
          if (last) begin
            Result   <= mul_lo;
            ResultHi <= mul_sum[WIDTH:1];
            Zero     <= (mul_lo == '0);
          end
        end
        DIV: begin
          cnt <= cnt - CNT_W'(1);
          hi  <= div_rem;
          lo  <= div_q;
          if (last) begin
            Result   <= div_q;
            ResultHi <= div_rem;
            Zero     <= (div_q == '0);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo (WIDTH=32).
// Scoreboard queue of expected results, popped on done.
module tb_alu_multiciclo;

  localparam int W = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   ALUControl;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic         Zero;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  alu_multiciclo #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .A(A),
    .B(B),
    .ALUControl(ALUControl),
    .Result(Result),
    .ResultHi(ResultHi),
    .Zero(Zero),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.res = '0;
    e.hi  = '0;
    e.dz  = 1'b0;
    p     = '0;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_SLT: e.res = (a < b) ? 1 : 0;
      OP_NOR: e.res = ~(a | b);
      OP_MULTU: begin
        p     = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.hi  = p[63:32];
      end
      OP_DIVU: begin
        if (b == 0) begin
          e.res = '1;
          e.hi  = a;
          e.dz  = 1'b1;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Called at a negedge; drives start there, returns at
  // the negedge of the done cycle.
  task automatic run_op(input logic [3:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit disturb);
    int   lat;
    int   n;
    bit   got;
    bit   iter;
    exp_t e;
    iter = (op == OP_MULTU) || (op == OP_DIVU && b != 0);
    lat  = iter ? W + 1 : 1;
    start = 1'b1;
    A = a;
    B = b;
    ALUControl = op;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    n   = 0;
    got = 0;
    while (n < lat + 4 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        A = $urandom;
        B = $urandom;
      end
      if (disturb && n == 5) begin
        start = 1'b1;
        ALUControl = OP_ADD;
        A = $urandom;
        B = $urandom;
      end
      if (disturb && n == 6) start = 1'b0;
      if (done) got = 1;
      chk("busy", busy, (iter && n < lat) ? 1 : 0);
    end
    chk("done_seen", done, 1);
    if (got) begin
      chk("latency", n, lat);
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Result", Result, e.res);
        chk("ResultHi", ResultHi, e.hi);
        chk("Zero", Zero, e.zero);
        chk("div_zero", div_zero, e.dz);
      end
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    ALUControl = '0;
    repeat (2) @(negedge clk);
    chk("rst_Result", Result, 0);
    chk("rst_ResultHi", ResultHi, 0);
    chk("rst_Zero", Zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div_zero", div_zero, 0);
    reset = 1'b0;

    run_op(OP_ADD, 5, 3, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);

    run_op(OP_SUB, 7, 7, 0);
    run_op(OP_SLT, 2, 9, 0);
    @(negedge clk);
    chk("b2b_done_pulse", done, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    run_op(OP_DIVU, 100, 7, 0);
    @(negedge clk);
    run_op(OP_DIVU, 5, 0, 0);
    @(negedge clk);
    chk("dz_hold_idle", div_zero, 1);
    run_op(OP_ADD, 1, 2, 0);
    @(negedge clk);
    run_op(OP_MULTU, 3, 4, 1);
    @(negedge clk);
    chk("hold_Result", Result, 12);
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    run_op(OP_OR, 32'hF000_0001, 32'h0000_0F10, 0);
    run_op(OP_NOR, 32'hFFFF_0000, 32'h0000_FF00, 0);
    run_op(4'b1111, 32'h1234, 32'h5678, 0);
    run_op(OP_DIVU, 7, 100, 0);
    run_op(OP_SLT, 9, 2, 0);
    run_op(OP_MULTU, 32'h8000_0000, 2, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_op((i % 2 == 0) ? OP_MULTU : OP_DIVU,
             $urandom, $urandom_range(1, 32'hFFFF), 0);
    end

    @(negedge clk);
    start = 1'b1;
    A = 100;
    B = 7;
    ALUControl = OP_DIVU;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_Result", Result, 0);
    chk("mid_rst_ResultHi", ResultHi, 0);
    chk("mid_rst_Zero", Zero, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_div_zero", div_zero, 0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    run_op(OP_ADD, 1, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
